// File: rtl/clk_div_bank_pkg.sv
// Shared defaults, divisor type and width helper for the clock divider bank.
package clk_div_pkg;

  localparam int DEF_NCH      = 4;
  localparam int DEF_CNT_W    = 24;
  localparam int DEF_DIV      = 4;
  localparam int DEF_PRESCALE = 25;

  // Divisor word at the default counter width.
  typedef logic [DEF_CNT_W-1:0] div_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor-write handshake between a configuring master and the divider bank.
interface clk_div_bank_if import clk_div_pkg::*; #(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [chWidth(NCH)-1:0]  cfg_ch;
  logic [CNT_W-1:0]         cfg_div;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active divisor, registered tick and square wave.
module clk_div_chan #(
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_step,
  input  logic             i_sync,
  input  logic             i_applyReq,
  input  logic [CNT_W-1:0] i_applyDiv,
  output logic             o_tick,
  output logic             o_sq,
  output logic             o_applied
);

  // Divisors 0 and 1 both mean "every step", so the stored divisor is never below 1.
  localparam logic [CNT_W-1:0] RESET_DIV =
    (DEFAULT_DIV < 2) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_tick;
  logic             r_sq;
  logic [CNT_W-1:0] w_newDiv;
  logic             w_run;
  logic             w_wrap;

  assign w_run    = i_en & i_step & ~i_sync;
  // A divisor applied while disabled may be below the held count; >= keeps
  // the channel from running all the way round the counter in that case.
  assign w_wrap   = w_run & (r_cnt >= (r_div - CNT_W'(1)));
  assign w_newDiv = (i_applyDiv < CNT_W'(2)) ? CNT_W'(1) : i_applyDiv;
  // A new divisor lands only where the count restarts (wrap or sync) or while idle.
  assign o_applied = i_applyReq & (i_sync | ~i_en | w_wrap);
  assign o_tick    = r_tick;
  assign o_sq      = r_sq;

  // Count step enables, wrap at div-1, and let sync override everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_div  <= RESET_DIV;
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else begin
      if (o_applied) r_div <= w_newDiv;
      if (i_sync) begin
        r_cnt  <= '0;
        r_sq   <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_sq   <= ~r_sq;
        r_tick <= 1'b1;
      end else begin
        r_tick <= 1'b0;
        if (w_run) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock-enable dividers with a single-slot divisor
// write port. Optional shared prescaler enabled by CLK_DIV_BANK_PRESCALE_EN.
module clk_div_bank import clk_div_pkg::*; #(
  parameter int NCH         = DEF_NCH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int PRESCALE    = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  clk_div_bank_if.slave    cfg,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  localparam int CH_W = chWidth(NCH);

  if (NCH < 1 || NCH > 16 || PRESCALE < 1) begin : g_badParam
    $error("clk_div_bank: NCH must be 1..16 and PRESCALE at least 1");
  end

  logic             r_pend;
  logic [CH_W-1:0]  r_pendCh;
  logic [CNT_W-1:0] r_pendDiv;
  logic             w_accept;
  logic             w_step;
  logic             w_applyValid;
  logic [CH_W-1:0]  w_applyCh;
  logic [CNT_W-1:0] w_applyDiv;
  logic [NCH-1:0]   w_applied;
  logic             w_pendDrop;

  assign cfg.cfg_ready = ~r_pend;
  assign w_accept      = cfg.cfg_valid & ~r_pend;
  // The slot empties once its channel takes the divisor, or at once if no such channel exists.
  assign w_pendDrop    = r_pend & ((|w_applied) | (int'(r_pendCh) >= NCH));

  // Offer the pending divisor; a write arriving together with sync bypasses the slot.
  always_comb begin
    w_applyValid = r_pend;
    w_applyCh    = r_pendCh;
    w_applyDiv   = r_pendDiv;
    if (w_accept && sync) begin
      w_applyValid = 1'b1;
      w_applyCh    = cfg.cfg_ch;
      w_applyDiv   = cfg.cfg_div;
    end
  end

  // Capture an accepted write into the slot, release it once applied or discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= 1'b0;
      r_pendCh  <= '0;
      r_pendDiv <= '0;
    end else if (w_pendDrop) begin
      r_pend <= 1'b0;
    end else if (w_accept && !sync) begin
      r_pend    <= 1'b1;
      r_pendCh  <= cfg.cfg_ch;
      r_pendDiv <= cfg.cfg_div;
    end
  end

`ifdef CLK_DIV_BANK_PRESCALE_EN
  localparam int PRE_W = chWidth(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre;

  assign w_step = (r_pre == PRE_LAST);

  // Shared prescaler: one step enable every PRESCALE clocks, realigned by sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (sync || w_step) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end
`else
  assign w_step = 1'b1;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (en[i]),
      .i_step     (w_step),
      .i_sync     (sync),
      .i_applyReq (w_applyValid && (w_applyCh == CH_W'(i))),
      .i_applyDiv (w_applyDiv),
      .o_tick     (tick[i]),
      .o_sq       (sq[i]),
      .o_applied  (w_applied[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank in its default build (no prescaler).
module tb_clk_div_bank;

  localparam int NCH   = 4;
  localparam int CNT_W = 24;

  typedef struct {
    logic [3:0]  en;
    logic        sync;
    logic        valid;
    logic [1:0]  ch;
    logic [23:0] div;
    logic [3:0]  expTick;
    logic [3:0]  expSq;
    logic        expReady;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic [3:0] en;
  logic [3:0] tick;
  logic [3:0] sq;

  int numChecks = 0;
  int numFails  = 0;
  int divs[4];
  vec_t vecs[12];

  clk_div_bank_if #(.NCH(NCH), .CNT_W(CNT_W)) cfgIf ();

  clk_div_bank #(
    .NCH(NCH), .CNT_W(CNT_W), .DEFAULT_DIV(4), .PRESCALE(25)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .cfg(cfgIf), .tick(tick), .sq(sq)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveCfg(input logic valid, input logic [1:0] ch, input logic [23:0] div);
    cfgIf.cfg_valid = valid;
    cfgIf.cfg_ch    = ch;
    cfgIf.cfg_div   = div;
  endtask

  task automatic applyStimulus(input vec_t v);
    en   = v.en;
    sync = v.sync;
    driveCfg(v.valid, v.ch, v.div);
    cycle();
  endtask

  // Load a divisor into a disabled channel: slot busy for one cycle, then free.
  task automatic writeIdle(input logic [1:0] ch, input logic [23:0] div);
    driveCfg(1'b1, ch, div);
    cycle();
    checkOutput("idle write busy", 32'(cfgIf.cfg_ready), 32'd0);
    driveCfg(1'b0, 2'd0, 24'd0);
    cycle();
    checkOutput("idle write done", 32'(cfgIf.cfg_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] eTick;
    logic [3:0] eSq;
    logic       eSq1;
    logic       eSq2;
    int         nTicks;

    // Channel 0 alone at the default divisor 4: tick every 4 cycles, sq period 8.
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0000, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0000, 4'b0000, 1'b1};
    vecs[2]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0000, 4'b0000, 1'b1};
    vecs[3]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0001, 4'b0001, 1'b1};
    vecs[4]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0000, 4'b0001, 1'b1};
    vecs[5]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0000, 4'b0001, 1'b1};
    vecs[6]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0000, 4'b0001, 1'b1};
    vecs[7]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0001, 4'b0000, 1'b1};
    vecs[8]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0000, 4'b0000, 1'b1};
    vecs[9]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0000, 4'b0000, 1'b1};
    vecs[10] = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0000, 4'b0000, 1'b1};
    vecs[11] = '{4'b0001, 1'b0, 1'b0, 2'd0, 24'd0, 4'b0001, 4'b0001, 1'b1};

    rst_n = 1'b1;
    en    = 4'b0000;
    sync  = 1'b0;
    driveCfg(1'b0, 2'd0, 24'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset tick", 32'(tick), 32'd0);
    checkOutput("reset sq", 32'(sq), 32'd0);
    checkOutput("reset ready", 32'(cfgIf.cfg_ready), 32'd1);
    cycle();
    cycle();
    rst_n = 1'b1;

    $display("[TB] default divisor on channel 0");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].expTick));
      checkOutput($sformatf("vec%0d sq", i), 32'(sq), 32'(vecs[i].expSq));
      checkOutput($sformatf("vec%0d ready", i), 32'(cfgIf.cfg_ready), 32'(vecs[i].expReady));
    end

    // Retarget ch0 to 10 just after a wrap: old period of 4 completes, then 10.
    $display("[TB] divisor change on running channel");
    driveCfg(1'b1, 2'd0, 24'd10);
    cycle();
    checkOutput("ch0 write busy", 32'(cfgIf.cfg_ready), 32'd0);
    checkOutput("ch0 write tick", 32'(tick[0]), 32'd0);
    driveCfg(1'b0, 2'd0, 24'd0);
    for (int j = 14; j <= 36; j++) begin
      cycle();
      checkOutput($sformatf("ch0 c%0d tick", j), 32'(tick[0]), 32'((j == 16) || (j == 26) || (j == 36)));
      checkOutput($sformatf("ch0 c%0d ready", j), 32'(cfgIf.cfg_ready), 32'(j >= 16));
      checkOutput($sformatf("ch0 c%0d sq", j), 32'(sq[0]),
                  32'((j < 16) ? 1 : (j < 26) ? 0 : (j < 36) ? 1 : 0));
    end

    // Divisors 0 and 1 on ch1: tick every cycle, sq toggling every cycle.
    $display("[TB] divisor 0 and 1 on channel 1");
    writeIdle(2'd1, 24'd0);
    en   = 4'b0011;
    eSq1 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      eSq1 = ~eSq1;
      checkOutput("div0 tick1", 32'(tick[1]), 32'd1);
      checkOutput("div0 sq1", 32'(sq[1]), 32'(eSq1));
    end
    driveCfg(1'b1, 2'd1, 24'd1);
    cycle();
    eSq1 = ~eSq1;
    checkOutput("div1 write busy", 32'(cfgIf.cfg_ready), 32'd0);
    checkOutput("div1 tick1 a", 32'(tick[1]), 32'd1);
    checkOutput("div1 sq1 a", 32'(sq[1]), 32'(eSq1));
    driveCfg(1'b0, 2'd0, 24'd0);
    cycle();
    eSq1 = ~eSq1;
    checkOutput("div1 write done", 32'(cfgIf.cfg_ready), 32'd1);
    for (int j = 0; j < 3; j++) begin
      checkOutput("div1 tick1", 32'(tick[1]), 32'd1);
      checkOutput("div1 sq1", 32'(sq[1]), 32'(eSq1));
      cycle();
      eSq1 = ~eSq1;
    end

    // Divisors 3,5,7,9, aligned by sync, then a second sync on a shared wrap.
    $display("[TB] sync alignment");
    en = 4'b0000;
    writeIdle(2'd0, 24'd3);
    writeIdle(2'd1, 24'd5);
    writeIdle(2'd2, 24'd7);
    writeIdle(2'd3, 24'd9);
    divs = '{3, 5, 7, 9};
    en   = 4'b1111;
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    checkOutput("sync0 tick", 32'(tick), 32'd0);
    checkOutput("sync0 sq", 32'(sq), 32'd0);
    for (int k = 1; k <= 14; k++) begin
      cycle();
      for (int i = 0; i < 4; i++) begin
        eTick[i] = (k % divs[i]) == 0;
        eSq[i]   = ((k / divs[i]) % 2) == 1;
      end
      checkOutput($sformatf("seg1 k%0d tick", k), 32'(tick), 32'(eTick));
      checkOutput($sformatf("seg1 k%0d sq", k), 32'(sq), 32'(eSq));
    end
    // Cycle 15 would wrap ch0 and ch1; sync suppresses it and a same-cycle write to ch3 applies now.
    sync = 1'b1;
    driveCfg(1'b1, 2'd3, 24'd4);
    cycle();
    sync = 1'b0;
    driveCfg(1'b0, 2'd0, 24'd0);
    checkOutput("sync1 tick", 32'(tick), 32'd0);
    checkOutput("sync1 sq", 32'(sq), 32'd0);
    checkOutput("sync1 ready", 32'(cfgIf.cfg_ready), 32'd1);
    divs[3] = 4;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      for (int i = 0; i < 4; i++) begin
        eTick[i] = (k % divs[i]) == 0;
        eSq[i]   = ((k / divs[i]) % 2) == 1;
      end
      checkOutput($sformatf("seg2 k%0d tick", k), 32'(tick), 32'(eTick));
      checkOutput($sformatf("seg2 k%0d sq", k), 32'(sq), 32'(eSq));
    end

    // ch2 now holds cnt=3, sq=1; pause it 6 cycles and load divisor 5 meanwhile.
    $display("[TB] channel 2 pause");
    en = 4'b1011;
    driveCfg(1'b1, 2'd2, 24'd5);
    cycle();
    driveCfg(1'b0, 2'd0, 24'd0);
    checkOutput("pause ready d1", 32'(cfgIf.cfg_ready), 32'd0);
    for (int d = 2; d <= 6; d++) begin
      checkOutput($sformatf("pause d%0d tick2", d - 1), 32'(tick[2]), 32'd0);
      checkOutput($sformatf("pause d%0d sq2", d - 1), 32'(sq[2]), 32'd1);
      cycle();
      if (d == 2) checkOutput("pause ready d2", 32'(cfgIf.cfg_ready), 32'd1);
    end
    checkOutput("pause d6 tick2", 32'(tick[2]), 32'd0);
    checkOutput("pause d6 sq2", 32'(sq[2]), 32'd1);
    en = 4'b1111;
    for (int r = 1; r <= 12; r++) begin
      cycle();
      nTicks = (r < 2) ? 0 : ((r - 2) / 5) + 1;
      eSq2   = 1'b1 ^ nTicks[0];
      checkOutput($sformatf("resume r%0d tick2", r), 32'(tick[2]), 32'((r == 2) || (r == 7) || (r == 12)));
      checkOutput($sformatf("resume r%0d sq2", r), 32'(sq[2]), 32'(eSq2));
    end

    // Reset while a write is pending drops it and restores divisor 4.
    $display("[TB] reset during write");
    en = 4'b0001;
    driveCfg(1'b1, 2'd0, 24'd9);
    cycle();
    driveCfg(1'b0, 2'd0, 24'd0);
    checkOutput("midwrite busy", 32'(cfgIf.cfg_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midwrite reset ready", 32'(cfgIf.cfg_ready), 32'd1);
    checkOutput("midwrite reset tick", 32'(tick), 32'd0);
    checkOutput("midwrite reset sq", 32'(sq), 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      checkOutput($sformatf("post reset k%0d tick0", k), 32'(tick[0]), 32'((k % 4) == 0));
      checkOutput($sformatf("post reset k%0d sq0", k), 32'(sq[0]), 32'((k >= 4) && (k < 8)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
